// File: rtl/ram_loader_pkg.sv
// Shared datapath definitions: loader FSM encoding and default RAM geometry
// used by the loader, the data RAM and the controller.
package ram_loader_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 8;

  typedef enum logic [1:0] {
    LDR_IDLE = 2'd0,
    LDR_LOAD = 2'd1,
    LDR_DONE = 2'd2
  } ldr_state_e;

endpackage

// File: rtl/ram_loader.sv
// Streams valid/ready words into RAM port A at consecutive addresses from BASE_ADDR.
// Optional running checksum of loaded words is built when RAM_LOADER_CHECKSUM_EN is defined.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_start,
  input  logic [ADDR_W:0]   cmd_len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [ADDR_W:0]   FULL_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

  ldr_state_e        state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              wea_q, wea_d;
  logic [ADDR_W-1:0] addra_q, addra_d;
  logic [DATA_W-1:0] dina_q, dina_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] sum_q, sum_d;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    wea_d   = 1'b0;
    addra_d = addra_q;
    dina_d  = dina_q;
    sum_d   = sum_q;
    case (state_q)
      LDR_IDLE: begin
        if (cmd_start) begin
          // Any length with the top bit set is at least a full RAM; clamp it.
          len_d   = cmd_len[ADDR_W] ? FULL_LEN : cmd_len;
          cnt_d   = '0;
          sum_d   = '0;
          state_d = (cmd_len == '0) ? LDR_DONE : LDR_LOAD;
        end
      end
      LDR_LOAD: begin
        if (in_valid) begin
          wea_d   = 1'b1;
          addra_d = BASE + cnt_q[ADDR_W-1:0];
          dina_d  = in_data;
          sum_d   = sum_q + in_data;
          cnt_d   = cnt_q + CNT_ONE;
          if (cnt_q == len_q - CNT_ONE) state_d = LDR_DONE;
        end
      end
      LDR_DONE: state_d = LDR_IDLE;
      default:  state_d = LDR_IDLE;
    endcase
    ready_d = (state_d == LDR_LOAD);
    busy_d  = (state_d != LDR_IDLE);
    done_d  = (state_d == LDR_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LDR_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      wea_q   <= 1'b0;
      addra_q <= '0;
      dina_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      wea_q   <= wea_d;
      addra_q <= addra_d;
      dina_q  <= dina_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
    end
  end

  assign in_ready = ready_q;
  assign wea      = wea_q;
  assign addra    = addra_q;
  assign dina     = dina_q;
  assign busy     = busy_q;
  assign done     = done_q;

`ifdef RAM_LOADER_CHECKSUM_EN
  assign checksum = sum_q;
`else
  // Accumulator is left unobserved so synthesis trims it away.
  logic unused_sum;
  assign unused_sum = ^sum_q;
  assign checksum   = '0;
`endif

endmodule

// File: doc/ram_loader.md
# ram_loader

Upstream fill stage for the dual-port data RAM in the state-machine datapath. Accepts a word stream over a valid/ready handshake and writes it into RAM port A (`wea`/`addra`/`dina`) at consecutive addresses starting from a base. Signals `done` once the programmed block length has been written, so the controller can then process the RAM contents.

## Interface
Parameters:
- `DATA_W`, default 32: word width, equal to the RAM `dina` width.
- `ADDR_W`, default 8: RAM address width.
- `BASE_ADDR`, default 0: first write address.

Ports:
- `clk`  in  1: system clock; all logic rises on the posedge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `cmd_start`  in  1: single-cycle request to begin a load.
- `cmd_len`  in  ADDR_W+1: number of words to load, 0..2^ADDR_W; sampled when `cmd_start` is accepted.
- `in_valid`  in  1: upstream word valid.
- `in_data`  in  DATA_W: upstream word.
- `in_ready`  out  1: loader can accept a word.
- `wea`  out  1: RAM port-A write enable.
- `addra`  out  ADDR_W: RAM port-A address.
- `dina`  out  DATA_W: RAM port-A data.
- `busy`  out  1: high from an accepted start until `done`.
- `done`  out  1: one-cycle pulse when the load is complete.
- `checksum`  out  DATA_W: running sum of the words loaded in the current or most recent load.

## Operation
- The FSM has three states: IDLE, LOAD and DONE.
- **IDLE:**
  - If `cmd_start` is high, latch `cmd_len`, clear the word counter and clear `checksum`.
  - Go to LOAD if `cmd_len` is not 0; otherwise go to DONE.
- **LOAD:**
  - `in_ready` is high.
  - A transfer occurs when `in_valid && in_ready`.
  - Each transfer registers `wea=1`, `addra=(BASE_ADDR+count) mod 2^ADDR_W` and `dina=in_data`, then increments the counter.
  - On the transfer where `count==len-1`, go to DONE.
  - If no transfer occurs in a cycle, `wea=0` the next cycle.
- **DONE:** `done=1` and `in_ready=0` for exactly one cycle, then go to IDLE.
- `busy` = (state != IDLE).
- `cmd_start` is ignored outside IDLE.
- `in_valid` outside LOAD is ignored and the data is dropped.
- Addresses wrap modulo 2^ADDR_W.
- `cmd_len = 2^ADDR_W` fills the whole RAM exactly once.
- `cmd_len` values above 2^ADDR_W are clamped to 2^ADDR_W.
- `addra` and `dina` hold their last values while `wea=0`.

## Timing
- **Reset values:** state IDLE, `in_ready=0`, `wea=0`, `addra=0`, `dina=0`, `busy=0`, `done=0`, `checksum=0`, counter 0.
- **Start to first accept:** `cmd_start` accepted at edge t makes `in_ready=1` from cycle t+1.
- **Write latency:** one cycle. A handshake in cycle t produces `wea` in cycle t+1, and the RAM commits at the end of t+1.
- **Throughput:** one word per cycle while `in_valid` stays high.
- **Completion:** for the final handshake in cycle t, the final `wea` and `done` are both high in cycle t+1. The RAM contents are stable for a port-B read issued at t+2.
- **Zero length:** `done` is high in the cycle after the start is accepted, and no write occurs.
- **Reset mid-load:** all outputs return to reset values immediately. RAM contents already written remain, and a partial load is not resumed.

## Configuration
- **Macro:** `RAM_LOADER_CHECKSUM_EN`.
- **Defined:** `checksum` accumulates each transferred `in_data` with modulo-2^DATA_W addition. The update appears in the same cycle as the corresponding `wea`, and the value holds after `done` until the next accepted start.
- **Undefined:** the accumulator is not built and `checksum` is a constant 0. All other behaviour is identical.

## Structure
- The shared datapath package holds:
  - the FSM state encoding (`LDR_IDLE`, `LDR_LOAD`, `LDR_DONE`);
  - the default `DATA_W` and `ADDR_W` constants, also used by the RAM and the controller.
- No sub-module: a single module containing the FSM, counter, output registers and the optional accumulator.

## Test plan
- **Basic load:** reset, `cmd_start` with len=4, words 0x11, 0x22, 0x33, 0x44 with continuous valid → writes at addra 0..3 on four consecutive cycles, `done` in the same cycle as the 4th `wea`, checksum=0xAA when the macro is defined.
- **Backpressure gaps:** len=3, `in_valid` toggling 1,0,1,0,1 → exactly 3 writes at addra 0,1,2; `wea` low in gap cycles; `busy` high throughout.
- **Zero length:** `cmd_start` with len=0 → `done` pulse one cycle later, `wea` never asserted, `in_ready` never high.
- **Wrap and full fill:** `BASE_ADDR=0xFE`, len=4 → addra 0xFE, 0xFF, 0x00, 0x01. Separately, len=256 → 256 writes, last at 0xFD.
- **Ignored inputs:** `cmd_start` during LOAD with a different length has no effect; `in_valid` in IDLE with 0xDEAD produces no write.
- **Reset mid-load:** assert `rst_n=0` after 2 of 5 words → all outputs 0 immediately; a new load of len=1 afterwards writes at `BASE_ADDR`.
